// File: rtl/bypass_source.sv
// Operand-forwarding producer: shadows in-flight writes through E/M/W, selects
// forwarded operands for the two ID sources, flags load-use stalls and drives the RF write port.

module bypass_sel #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] i_src,
  input  logic          i_e_wen,
  input  logic [AW-1:0] i_e_dest,
  input  logic          i_e_load,
  input  logic          i_m_wen,
  input  logic [AW-1:0] i_m_dest,
  input  logic          i_m_pend,
  input  logic [DW-1:0] i_m_value,
  input  logic          i_w_wen,
  input  logic [AW-1:0] i_w_dest,
  input  logic [DW-1:0] i_w_value,
  input  logic [DW-1:0] i_exe_result,
  input  logic [DW-1:0] i_rf_data,
  output logic [1:0]    o_fwd,
  output logic [DW-1:0] o_value,
  output logic          o_stall
);
  // Youngest producer wins; register 0 is never forwarded.
  always_comb begin
    o_fwd   = 2'b00;
    o_value = i_rf_data;
    o_stall = 1'b0;
    if (i_src != '0) begin
      if (i_e_wen && i_e_dest == i_src) begin
        o_fwd   = 2'b01;
        o_value = i_exe_result;
        o_stall = i_e_load;
      end else if (i_m_wen && i_m_dest == i_src) begin
        o_fwd   = 2'b10;
        o_value = i_m_value;
        o_stall = i_m_pend;
      end else if (i_w_wen && i_w_dest == i_src) begin
        o_fwd   = 2'b11;
        o_value = i_w_value;
      end
    end
  end
endmodule

module bypass_source #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          adv,
  input  logic          id_fire,
  input  logic [AW-1:0] id_wdest,
  input  logic          id_wen,
  input  logic          id_load,
  input  logic          flush,
  input  logic [DW-1:0] exe_result,
  input  logic [DW-1:0] mem_load_data,
  input  logic          mem_load_valid,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  input  logic [DW-1:0] rf_rs_data,
  input  logic [DW-1:0] rf_rt_data,
  output logic [DW-1:0] rs_value,
  output logic [DW-1:0] rt_value,
  output logic [1:0]    forwardA,
  output logic [1:0]    forwardB,
  output logic          stall,
  output logic          wb_wen,
  output logic [AW-1:0] wb_wdest,
  output logic [DW-1:0] wb_wdata
);
  logic          r_e_wen, r_e_load;
  logic [AW-1:0] r_e_dest;
  logic          r_m_wen, r_m_load, r_m_dvalid;
  logic [AW-1:0] r_m_dest;
  logic [DW-1:0] r_m_data;
  logic          r_w_wen;
  logic [AW-1:0] r_w_dest;
  logic [DW-1:0] r_w_data;

  logic          w_m_capture, w_m_pend;
  logic [DW-1:0] w_m_value;

  assign w_m_capture = r_m_load && !r_m_dvalid && mem_load_valid;
  assign w_m_pend    = r_m_load && !r_m_dvalid && !mem_load_valid;
  assign w_m_value   = w_m_capture ? mem_load_data : r_m_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e_wen    <= 1'b0;
      r_e_dest   <= '0;
      r_e_load   <= 1'b0;
      r_m_wen    <= 1'b0;
      r_m_dest   <= '0;
      r_m_load   <= 1'b0;
      r_m_data   <= '0;
      r_m_dvalid <= 1'b0;
      r_w_wen    <= 1'b0;
      r_w_dest   <= '0;
      r_w_data   <= '0;
    end else if (adv) begin
      r_w_wen  <= r_m_wen;
      r_w_dest <= r_m_dest;
      r_w_data <= (r_m_load && mem_load_valid) ? mem_load_data : r_m_data;
      if (flush) begin
        r_m_wen    <= 1'b0;
        r_m_dest   <= '0;
        r_m_load   <= 1'b0;
        r_m_data   <= '0;
        r_m_dvalid <= 1'b0;
      end else begin
        r_m_wen    <= r_e_wen;
        r_m_dest   <= r_e_dest;
        r_m_load   <= r_e_load;
        r_m_data   <= exe_result;
        r_m_dvalid <= !r_e_load;
      end
      r_e_wen  <= id_fire && id_wen;
      r_e_dest <= id_fire ? id_wdest : '0;
      r_e_load <= id_fire && id_load;
    end else begin
      // Late load data lands in M while the pipe is held.
      if (w_m_capture) begin
        r_m_data   <= mem_load_data;
        r_m_dvalid <= 1'b1;
      end
      if (flush) r_e_wen <= 1'b0;
    end
  end

  logic [1:0][AW-1:0] w_src;
  logic [1:0][DW-1:0] w_rf, w_val;
  logic [1:0][1:0]    w_fwd;
  logic [1:0]         w_stl;

  assign w_src = {rt, rs};
  assign w_rf  = {rf_rt_data, rf_rs_data};

  for (genvar g = 0; g < 2; g++) begin : g_sel
    bypass_sel #(.DW(DW), .AW(AW)) u_sel (
      .i_src        (w_src[g]),
      .i_e_wen      (r_e_wen),
      .i_e_dest     (r_e_dest),
      .i_e_load     (r_e_load),
      .i_m_wen      (r_m_wen),
      .i_m_dest     (r_m_dest),
      .i_m_pend     (w_m_pend),
      .i_m_value    (w_m_value),
      .i_w_wen      (r_w_wen),
      .i_w_dest     (r_w_dest),
      .i_w_value    (r_w_data),
      .i_exe_result (exe_result),
      .i_rf_data    (w_rf[g]),
      .o_fwd        (w_fwd[g]),
      .o_value      (w_val[g]),
      .o_stall      (w_stl[g])
    );
  end

  assign forwardA = w_fwd[0];
  assign forwardB = w_fwd[1];
  assign rs_value = w_val[0];
  assign rt_value = w_val[1];
  assign stall    = |w_stl;
  assign wb_wen   = r_w_wen;
  assign wb_wdest = r_w_dest;
  assign wb_wdata = r_w_data;
endmodule

// File: tb/tb_bypass_source.sv
// Random plus directed bench for bypass_source against an in-flight list model
// (slot 0 = youngest/E, 1 = M, 2 = W).

module tb_bypass_source;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 0, reset = 1, adv = 0, id_fire = 0, id_wen = 0, id_load = 0, flush = 0;
  logic [AW-1:0] id_wdest = 0, rs = 0, rt = 0;
  logic [DW-1:0] exe_result = 0, mem_load_data = 0, rf_rs_data = 0, rf_rt_data = 0;
  logic          mem_load_valid = 0;
  logic [DW-1:0] rs_value, rt_value, wb_wdata;
  logic [1:0]    forwardA, forwardB;
  logic          stall, wb_wen;
  logic [AW-1:0] wb_wdest;

  bypass_source #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .adv(adv), .id_fire(id_fire), .id_wdest(id_wdest),
    .id_wen(id_wen), .id_load(id_load), .flush(flush), .exe_result(exe_result),
    .mem_load_data(mem_load_data), .mem_load_valid(mem_load_valid), .rs(rs), .rt(rt),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .rs_value(rs_value),
    .rt_value(rt_value), .forwardA(forwardA), .forwardB(forwardB), .stall(stall),
    .wb_wen(wb_wen), .wb_wdest(wb_wdest), .wb_wdata(wb_wdata));

  always #5 clk = ~clk;

  // In-flight instruction list, youngest first.
  bit            m_wen[3], m_load[3], m_dv[3];
  logic [AW-1:0] m_dest[3];
  logic [DW-1:0] m_data[3];

  int vectors = 0, miscompares = 0;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, got timeout exp completion");
    $fatal(1, "timeout");
  end

  function automatic void model_clear();
    for (int k = 0; k < 3; k++) begin
      m_wen[k] = 0; m_load[k] = 0; m_dv[k] = 0; m_dest[k] = '0; m_data[k] = '0;
    end
  endfunction

  function automatic void model_src(input logic [AW-1:0] s, input logic [DW-1:0] rf,
                                    output logic [1:0] code, output logic [DW-1:0] val,
                                    output bit stl);
    bit pend;
    code = 2'b00; val = rf; stl = 0;
    for (int k = 0; k < 3; k++) begin
      if (code == 2'b00 && m_wen[k] && m_dest[k] != 0 && m_dest[k] == s) begin
        code = 2'(k + 1);
        if (k == 0) begin
          val = exe_result; stl = m_load[0];
        end else if (k == 1) begin
          pend = m_load[1] && !m_dv[1];
          val  = (pend && mem_load_valid) ? mem_load_data : m_data[1];
          stl  = pend && !mem_load_valid;
        end else begin
          val = m_data[2];
        end
      end
    end
  endfunction

  function automatic bit model_stall();
    logic [1:0] c; logic [DW-1:0] v; bit sa, sb;
    model_src(rs, rf_rs_data, c, v, sa);
    model_src(rt, rf_rt_data, c, v, sb);
    return sa || sb;
  endfunction

  function automatic void model_seq();
    if (reset) begin
      model_clear();
    end else if (adv) begin
      m_wen[2]  = m_wen[1];
      m_dest[2] = m_dest[1];
      m_data[2] = (m_load[1] && mem_load_valid) ? mem_load_data : m_data[1];
      m_load[2] = m_load[1];
      m_dv[2]   = 1;
      if (flush) begin
        m_wen[1] = 0; m_dest[1] = '0; m_load[1] = 0; m_data[1] = '0; m_dv[1] = 0;
      end else begin
        m_wen[1] = m_wen[0]; m_dest[1] = m_dest[0]; m_load[1] = m_load[0];
        m_data[1] = exe_result; m_dv[1] = !m_load[0];
      end
      m_wen[0]  = id_fire && id_wen;
      m_dest[0] = id_fire ? id_wdest : '0;
      m_load[0] = id_fire && id_load;
      m_data[0] = '0;
      m_dv[0]   = 0;
    end else begin
      if (m_load[1] && !m_dv[1] && mem_load_valid) begin
        m_data[1] = mem_load_data; m_dv[1] = 1;
      end
      if (flush) m_wen[0] = 0;
    end
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h exp %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic eval();
    logic [1:0] ca, cb; logic [DW-1:0] va, vb; bit sa, sb;
    #1;
    if (reset) model_clear();
    model_src(rs, rf_rs_data, ca, va, sa);
    model_src(rt, rf_rt_data, cb, vb, sb);
    chk("forwardA", DW'(forwardA), DW'(ca));
    chk("forwardB", DW'(forwardB), DW'(cb));
    chk("rs_value", rs_value, va);
    chk("rt_value", rt_value, vb);
    chk("stall", DW'(stall), DW'(sa || sb));
    chk("wb_wen", DW'(wb_wen), DW'(m_wen[2]));
    chk("wb_wdest", DW'(wb_wdest), DW'(m_dest[2]));
    chk("wb_wdata", wb_wdata, m_data[2]);
  endtask

  task automatic clk_edge();
    @(posedge clk);
    model_seq();
    @(negedge clk);
  endtask

  task automatic issue(input logic [AW-1:0] d, input logic w, input logic ld);
    adv = 1; id_fire = 1; id_wdest = d; id_wen = w; id_load = ld;
    eval(); clk_edge();
    id_fire = 0; id_wen = 0; id_load = 0; id_wdest = 0;
  endtask

  task automatic drain();
    adv = 1; id_fire = 0; flush = 0;
    repeat (3) begin eval(); clk_edge(); end
    adv = 0;
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    // Reset state
    rf_rs_data = 32'h1234;
    eval();
    chk("lit_reset_stall", DW'(stall), 0);
    chk("lit_reset_fA", DW'(forwardA), 0);
    chk("lit_reset_wbwen", DW'(wb_wen), 0);
    chk("lit_reset_rsval", rs_value, 32'h1234);
    clk_edge();
    reset = 0;

    // Back-to-back ALU dependence through E, M, W
    issue(5, 1, 0);
    adv = 0; rs = 5; exe_result = 32'hAA;
    eval();
    chk("lit_alu_E_code", DW'(forwardA), 1);
    chk("lit_alu_E_val", rs_value, 32'hAA);
    adv = 1; clk_edge();
    exe_result = 32'h0;
    eval();
    chk("lit_alu_M_code", DW'(forwardA), 2);
    chk("lit_alu_M_val", rs_value, 32'hAA);
    clk_edge();
    eval();
    chk("lit_alu_W_code", DW'(forwardA), 3);
    chk("lit_alu_W_val", rs_value, 32'hAA);
    chk("lit_alu_W_wen", DW'(wb_wen), 1);
    chk("lit_alu_W_dest", DW'(wb_wdest), 5);
    rs = 0; drain();

    // Load-use
    issue(7, 1, 1);
    adv = 0; rt = 7;
    eval();
    chk("lit_lu_stall_E", DW'(stall), 1);
    adv = 1; clk_edge();
    adv = 0; mem_load_valid = 1; mem_load_data = 32'h55;
    eval();
    chk("lit_lu_stall_M", DW'(stall), 0);
    chk("lit_lu_fB", DW'(forwardB), 2);
    chk("lit_lu_rtval", rt_value, 32'h55);
    drain();
    mem_load_valid = 0; rt = 0;

    // Priority E over W
    issue(3, 1, 0);
    exe_result = 32'h22; adv = 1;
    eval(); clk_edge();
    exe_result = 32'h0;
    issue(3, 1, 0);
    adv = 0; exe_result = 32'h11; rs = 3; rt = 3;
    eval();
    chk("lit_pri_fA", DW'(forwardA), 1);
    chk("lit_pri_fB", DW'(forwardB), 1);
    chk("lit_pri_rsval", rs_value, 32'h11);
    chk("lit_pri_rtval", rt_value, 32'h11);
    rs = 0; rt = 0; drain();

    // Register 0 never forwards
    issue(0, 1, 0);
    adv = 0; rs = 0; rf_rs_data = 32'h77;
    eval();
    chk("lit_r0_fA", DW'(forwardA), 0);
    chk("lit_r0_val", rs_value, 32'h77);
    drain();

    // Flush with adv kills the E entry
    issue(9, 1, 0);
    adv = 1; flush = 1;
    eval(); clk_edge();
    flush = 0; adv = 0; rs = 9;
    eval();
    chk("lit_fl_fA", DW'(forwardA), 0);
    adv = 1;
    clk_edge(); eval();
    chk("lit_fl_wbwen1", DW'(wb_wen), 0);
    clk_edge(); eval();
    chk("lit_fl_wbwen2", DW'(wb_wen), 0);
    drain();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(199) == 0);
      adv            = ($urandom_range(3) != 0);
      flush          = ($urandom_range(9) == 0);
      id_fire        = $urandom_range(1);
      id_wen         = ($urandom_range(4) != 0);
      id_load        = ($urandom_range(2) == 0);
      id_wdest       = AW'($urandom_range(7));
      rs             = AW'($urandom_range(7));
      rt             = AW'($urandom_range(7));
      exe_result     = $urandom;
      mem_load_data  = $urandom;
      mem_load_valid = $urandom_range(1);
      rf_rs_data     = $urandom;
      rf_rt_data     = $urandom;
      if (!reset && model_stall()) id_fire = 0;
      eval();
      clk_edge();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
